// File: rtl/fpu_issue_sched.sv
// Issue scheduler sharing one FP pipeline between two requesters.
// Round-robin arbitration, a tag pipeline that follows each operation through
// the datapath, and per-requester result FIFOs guarded by credit counters.
module fpu_issue_sched #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [1:0]  r0_op,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [1:0]  r1_op,
  output logic        r1_ready,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  input  logic [31:0] fpu_result,
  output logic        o0_valid,
  output logic [31:0] o0_data,
  input  logic        o0_ready,
  output logic        o1_valid,
  output logic [31:0] o1_data,
  input  logic        o1_ready,
  output logic        busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Requester fields gathered into arrays indexed by requester id
  logic [1:0]  req_valid;
  logic [31:0] req_a  [2];
  logic [31:0] req_b  [2];
  logic [1:0]  req_op [2];
  logic [1:0]  o_ready;

  assign req_valid = {r1_valid, r0_valid};
  assign req_a[0]  = r0_a;
  assign req_a[1]  = r1_a;
  assign req_b[0]  = r0_b;
  assign req_b[1]  = r1_b;
  assign req_op[0] = r0_op;
  assign req_op[1] = r1_op;
  assign o_ready   = {o1_ready, o0_ready};

  // State
  logic [CW-1:0]      credit_q [2];
  logic [CW-1:0]      credit_d [2];
  logic               last_grant_q, last_grant_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;
  logic [31:0]        mem_q [2][DEPTH];
  logic [31:0]        mem_d [2][DEPTH];
  logic [PW-1:0]      rptr_q [2];
  logic [PW-1:0]      rptr_d [2];
  logic [PW-1:0]      wptr_q [2];
  logic [PW-1:0]      wptr_d [2];
  logic [CW-1:0]      cnt_q [2];
  logic [CW-1:0]      cnt_d [2];

  logic [1:0] elig;
  logic [1:0] gnt;
  logic [1:0] pop;
  logic [1:0] push;
  logic       issue;
  logic       gnt_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO handshakes: a pop is a consumer taking a non-empty head; a push is
  // the tag pipeline tail delivering a live result to its owner.
  always_comb begin
    pop  = '0;
    push = '0;
    for (int i = 0; i < 2; i++) begin
      pop[i] = (cnt_q[i] != '0) && o_ready[i];
    end
    push[0] = tag_vld_q[LATENCY-1] && !tag_id_q[LATENCY-1];
    push[1] = tag_vld_q[LATENCY-1] && tag_id_q[LATENCY-1];
  end

  // Round-robin arbitration; a same-cycle pop frees its credit immediately
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] && ((credit_q[i] - CW'(pop[i])) < CW'(DEPTH));
    end
    if (&elig) begin
      gnt = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      gnt = elig;
    end
    issue  = |gnt;
    gnt_id = gnt[1];
  end

  // Pipeline operand-capture inputs and requester/consumer-facing outputs
  always_comb begin
    r0_ready = gnt[0];
    r1_ready = gnt[1];
    fpu_a    = issue ? req_a[gnt_id]  : '0;
    fpu_b    = issue ? req_b[gnt_id]  : '0;
    fpu_op   = issue ? req_op[gnt_id] : '0;
    o0_valid = cnt_q[0] != '0;
    o1_valid = cnt_q[1] != '0;
    o0_data  = o0_valid ? mem_q[0][rptr_q[0]] : '0;
    o1_data  = o1_valid ? mem_q[1][rptr_q[1]] : '0;
    busy     = (credit_q[0] != '0) || (credit_q[1] != '0);
  end

  // Next state: tag shift, grant history, credits and FIFO bookkeeping
  always_comb begin
    last_grant_d = issue ? gnt_id : last_grant_q;
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = issue;
    tag_id_d[0]  = gnt_id;
    for (int s = 1; s < LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
    mem_d = mem_q;
    for (int i = 0; i < 2; i++) begin
      credit_d[i] = credit_q[i] + CW'(gnt[i]) - CW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      rptr_d[i]   = pop[i] ? ptr_inc(rptr_q[i]) : rptr_q[i];
      wptr_d[i]   = push[i] ? ptr_inc(wptr_q[i]) : wptr_q[i];
      if (push[i]) begin
        mem_d[i][wptr_q[i]] = fpu_result;
      end
    end
  end

  // Control state with synchronous reset; in-flight tags are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        credit_q[i] <= '0;
        cnt_q[i]    <= '0;
        rptr_q[i]   <= '0;
        wptr_q[i]   <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      for (int i = 0; i < 2; i++) begin
        credit_q[i] <= credit_d[i];
        cnt_q[i]    <= cnt_d[i];
        rptr_q[i]   <= rptr_d[i];
        wptr_q[i]   <= wptr_d[i];
      end
    end
  end

  // FIFO storage needs no reset: outputs are masked while a FIFO is empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed bench for fpu_issue_sched (LATENCY=3, DEPTH=2). The bench plays the
// FP pipeline by driving fpu_result by hand in the cycle each result is due.
module tb_fpu_issue_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [1:0]  r0_op, r1_op;
  logic        r0_ready, r1_ready;
  logic [31:0] fpu_a, fpu_b;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_result;
  logic        o0_valid, o1_valid;
  logic [31:0] o0_data, o1_data;
  logic        o0_ready, o1_ready;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  fpu_issue_sched #(
    .LATENCY(3),
    .DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r0_op     (r0_op),
    .r0_ready  (r0_ready),
    .r1_valid  (r1_valid),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .r1_op     (r1_op),
    .r1_ready  (r1_ready),
    .fpu_a     (fpu_a),
    .fpu_b     (fpu_b),
    .fpu_op    (fpu_op),
    .fpu_result(fpu_result),
    .o0_valid  (o0_valid),
    .o0_data   (o0_data),
    .o0_ready  (o0_ready),
    .o1_valid  (o1_valid),
    .o1_data   (o1_data),
    .o1_ready  (o1_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 0; r1_valid = 0;
    r0_a = 0; r0_b = 0; r0_op = 0;
    r1_a = 0; r1_b = 0; r1_op = 0;
    fpu_result = 0; o0_ready = 0; o1_ready = 0;
    nxt(); nxt();
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_o0_valid", 32'(o0_valid), 0);
    chk("rst_o1_valid", 32'(o1_valid), 0);
    chk("rst_o0_data", o0_data, 0);
    chk("rst_r0_ready", 32'(r0_ready), 0);
    chk("rst_fpu_a", fpu_a, 0);
    rst = 1'b0;
    nxt();

    // Single op from requester 0
    r0_valid = 1; r0_a = 32'h3F80_0000; r0_b = 32'h4000_0000; r0_op = 2'd0;
    #1;
    chk("single_r0_ready", 32'(r0_ready), 1);
    chk("single_r1_ready", 32'(r1_ready), 0);
    chk("single_fpu_a", fpu_a, 32'h3F80_0000);
    chk("single_fpu_b", fpu_b, 32'h4000_0000);
    chk("single_fpu_op", 32'(fpu_op), 0);
    nxt();
    r0_valid = 0; #1;
    chk("single_busy", 32'(busy), 1);
    nxt();
    nxt();
    fpu_result = 32'h4040_0000; #1;
    chk("single_o0_early", 32'(o0_valid), 0);
    nxt();
    fpu_result = 0; o0_ready = 1; #1;
    chk("single_o0_valid", 32'(o0_valid), 1);
    chk("single_o0_data", o0_data, 32'h4040_0000);
    chk("single_o1_valid", 32'(o1_valid), 0);
    chk("single_busy_hold", 32'(busy), 1);
    nxt();
    o0_ready = 0; #1;
    chk("single_o0_popped", 32'(o0_valid), 0);
    chk("single_busy_drop", 32'(busy), 0);

    // Fresh reset so the first tie goes to requester 0
    rst = 1; nxt(); rst = 0;

    // Tie and alternation, then in-order routing with both consumers ready
    o0_ready = 1; o1_ready = 1;
    for (int k = 0; k < 8; k++) begin
      r0_valid = (k < 4); r1_valid = (k < 4);
      r0_a = 32'h1000_0000 + 32'(k); r0_b = 32'h1100_0000 + 32'(k); r0_op = 2'd1;
      r1_a = 32'h2000_0000 + 32'(k); r1_b = 32'h2200_0000 + 32'(k); r1_op = 2'd2;
      fpu_result = (k >= 3 && k <= 6) ? 32'hC000_0000 + 32'(k - 3) : 32'h0;
      #1;
      if (k < 4) begin
        chk($sformatf("tie%0d_r0_ready", k), 32'(r0_ready), 32'(k % 2 == 0));
        chk($sformatf("tie%0d_r1_ready", k), 32'(r1_ready), 32'(k % 2 == 1));
        chk($sformatf("tie%0d_fpu_a", k), fpu_a,
            (k % 2 == 0) ? 32'h1000_0000 + 32'(k) : 32'h2000_0000 + 32'(k));
        chk($sformatf("tie%0d_fpu_op", k), 32'(fpu_op), (k % 2 == 0) ? 1 : 2);
      end else begin
        chk($sformatf("ret%0d_o0_valid", k), 32'(o0_valid), 32'(k % 2 == 0));
        chk($sformatf("ret%0d_o1_valid", k), 32'(o1_valid), 32'(k % 2 == 1));
        chk($sformatf("ret%0d_data", k), (k % 2 == 0) ? o0_data : o1_data,
            32'hC000_0000 + 32'(k - 4));
      end
      nxt();
    end
    #1;
    chk("tie_end_busy", 32'(busy), 0);
    chk("tie_end_o0_valid", 32'(o0_valid), 0);

    // Credit stall on requester 0
    o0_ready = 0; o1_ready = 1;
    r0_valid = 1; r0_a = 32'h3000_0000; r1_valid = 0; r1_a = 32'h4000_0001;
    #1; chk("stall_e0_r0_ready", 32'(r0_ready), 1);
    nxt();
    #1; chk("stall_e1_r0_ready", 32'(r0_ready), 1);
    nxt();
    r1_valid = 1; #1;
    chk("stall_e2_r0_ready", 32'(r0_ready), 0);
    chk("stall_e2_r1_ready", 32'(r1_ready), 1);
    chk("stall_e2_fpu_a", fpu_a, 32'h4000_0001);
    nxt();
    r1_valid = 0; fpu_result = 32'hD000_0000; #1;
    chk("stall_e3_r0_ready", 32'(r0_ready), 0);
    nxt();
    fpu_result = 32'hD000_0001; #1;
    chk("stall_e4_r0_ready", 32'(r0_ready), 0);
    chk("stall_e4_o0_valid", 32'(o0_valid), 1);
    chk("stall_e4_o0_data", o0_data, 32'hD000_0000);
    nxt();
    fpu_result = 32'hD000_0002; #1;
    chk("stall_e5_r0_ready", 32'(r0_ready), 0);
    nxt();
    fpu_result = 0; o0_ready = 1; #1;
    chk("stall_e6_pop_ready", 32'(r0_ready), 1);
    chk("stall_e6_o0_data", o0_data, 32'hD000_0000);
    chk("stall_e6_o1_data", o1_data, 32'hD000_0002);
    nxt();
    o0_ready = 0; #1;
    chk("stall_e7_r0_ready", 32'(r0_ready), 0);
    chk("stall_e7_o0_data", o0_data, 32'hD000_0001);
    chk("stall_e7_o1_valid", 32'(o1_valid), 0);
    nxt();
    r0_valid = 0;
    nxt();
    // Push and pop together on a one-entry FIFO
    fpu_result = 32'hD000_0003; o0_ready = 1; #1;
    chk("pp_e9_o0_data", o0_data, 32'hD000_0001);
    nxt();
    fpu_result = 0; o0_ready = 0; #1;
    chk("pp_e10_o0_valid", 32'(o0_valid), 1);
    chk("pp_e10_o0_data", o0_data, 32'hD000_0003);
    nxt();
    o0_ready = 1;
    nxt();
    o0_ready = 0; #1;
    chk("pp_e12_o0_valid", 32'(o0_valid), 0);
    chk("pp_e12_busy", 32'(busy), 0);

    // Reset while two ops are in flight
    r0_valid = 1; r0_a = 32'h5000_0000;
    nxt();
    rst = 1;
    nxt();
    rst = 0; r0_valid = 0; #1;
    chk("rstmf_busy", 32'(busy), 0);
    chk("rstmf_o0_valid_f2", 32'(o0_valid), 0);
    for (int k = 3; k < 7; k++) begin
      nxt();
      fpu_result = (k == 3) ? 32'hFFFF_FFFF : (k == 4) ? 32'h1234_5678 : 32'h0;
      #1;
      chk($sformatf("rstmf_o0_valid_f%0d", k), 32'(o0_valid), 0);
    end
    nxt();
    fpu_result = 0; r0_valid = 1; r1_valid = 1; r0_a = 32'h6000_0000; r1_a = 32'h7000_0000;
    #1;
    chk("rstmf_tie_r0", 32'(r0_ready), 1);
    chk("rstmf_tie_r1", 32'(r1_ready), 0);
    chk("rstmf_tie_fpu_a", fpu_a, 32'h6000_0000);
    nxt();

    // Idle cycle: zero operands and no FIFO write when its slot reaches the tail
    r0_valid = 0; r1_valid = 0; r0_op = 2'd3; r1_op = 2'd3; #1;
    chk("idle_fpu_a", fpu_a, 0);
    chk("idle_fpu_b", fpu_b, 0);
    chk("idle_fpu_op", 32'(fpu_op), 0);
    nxt();
    nxt();
    fpu_result = 32'hAAAA_AAAA;
    nxt();
    fpu_result = 32'h5555_5555; o0_ready = 1; #1;
    chk("idle_prev_o0_data", o0_data, 32'hAAAA_AAAA);
    nxt();
    fpu_result = 0; o0_ready = 0; #1;
    chk("idle_o0_valid", 32'(o0_valid), 0);
    chk("idle_o1_valid", 32'(o1_valid), 0);
    chk("idle_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_issue_sched.md
# fpu_issue_sched

Issue scheduler that shares the single floating-point pipeline between two requesters. It arbitrates operand/operator requests round-robin and drives the pipeline's operand-capture inputs. It tracks each in-flight operation by requester ID and routes each result back into a per-requester result FIFO. Credit counters guarantee that every result issued to the pipeline has a FIFO slot waiting when it emerges. The block sits between the requesting units and the fetch stage of the FPU datapath.

## Interface
- LATENCY, 3: cycles from an issue cycle (fpu_* driven) to the cycle fpu_result carries that operation's result; legal 1..15.
- DEPTH, 2: per-requester result FIFO entries and maximum outstanding operations per requester; legal 1..8.

- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- r0_valid / r1_valid  in  1  requester N presents an operation.
- r0_a, r0_b / r1_a, r1_b  in  32  operands, IEEE-754 single.
- r0_op / r1_op  in  2  operator code, passed through unmodified.
- r0_ready / r1_ready  out  1  request accepted this cycle (valid && ready = issue).
- fpu_a, fpu_b  out  32  operands to the FPU fetch-stage inputs.
- fpu_op  out  2  operator to the FPU fetch-stage input.
- fpu_result  in  32  FPU result, meaningful exactly LATENCY cycles after its issue cycle.
- o0_valid / o1_valid  out  1  result FIFO N is non-empty.
- o0_data / o1_data  out  32  head of result FIFO N.
- o0_ready / o1_ready  in  1  consumer pops FIFO N when valid && ready.
- busy  out  1  any credit counter non-zero.

## Operation
- Eligibility: requester N is eligible when rN_valid=1 and credit[N] < DEPTH.
- Arbitration:
  - Issue at most one operation per cycle.
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one that is not last_grant.
  - last_grant updates only on an issue. Reset value is 1, so requester 0 wins the first tie.
- rN_ready = grant to N. It is combinational from rN_valid, credits and last_grant. Holding rN_ready high while rN_valid=0 is not allowed.
- fpu_a/fpu_b/fpu_op: on a grant, carry the granted requester's fields; with no grant, carry all zeros.
- Tag pipeline: a LATENCY-deep shift register of {vld, id}.
  - Stage 0 is loaded with {issue, granted id} each cycle.
  - When the tail has vld=1, fpu_result is written into FIFO[id].
  - When the tail has vld=0, fpu_result is ignored.
- credit[N] update rules:
  - +1 on issue to N.
  - −1 on pop of FIFO N.
  - Unchanged when both happen in the same cycle.
  - Width is clog2(DEPTH+1). credit never exceeds DEPTH, so a FIFO write can never find the FIFO full.
- Result FIFOs:
  - Circular, with wrapping read and write pointers plus a count.
  - A push and a pop in the same cycle on a non-empty FIFO leave the count unchanged.
  - A push to an empty FIFO becomes visible at the head on the next cycle.
- Results return to each requester in issue order. There is no ordering guarantee between requesters.
- Reset is synchronous, on any cycle:
  - Clears the tag pipeline, FIFO pointers and counts, and credits; sets last_grant=1.
  - In-flight operations are discarded. No result is delivered for them.
  - Reset values: rN_ready=0 (until a valid arrives), fpu_*=0, oN_valid=0, oN_data=0, busy=0.

## Timing
- Issue at cycle T (rN_valid && rN_ready sampled at edge T). fpu_result for that operation is sampled at edge T+LATENCY. oN_valid=1 with the result on oN_data from cycle T+LATENCY+1.
- Throughput is one issue per cycle across both requesters.
- Per requester, at most DEPTH operations are either in flight or buffered.
- With no pops, requester N stalls (rN_ready=0) after DEPTH issues.
- rN_ready rises in the same cycle as the pop that frees a credit, because credit is compared against its registered value minus the pop.
- busy reflects the registered credits; it drops the cycle after the final pop.

## Test plan
- Single op: r0_valid=1, a=0x3F800000, b=0x40000000, op=0 at cycle 0.
  - Required: r0_ready=1 at cycle 0 and fpu_a/b/op equal the request.
  - With the bench returning fpu_result=0x40400000 at cycle 3 (LATENCY=3): o0_valid=1 and o0_data=0x40400000 at cycle 4; o1_valid stays 0.
- Tie and alternation: both valid every cycle for 4 cycles.
  - Required: grants go 0,1,0,1, and fpu_a matches the granted operand each cycle.
  - With o0_ready=o1_ready=1, results route to the correct ports in order.
- Credit stall: r0_valid held high, o0_ready=0, DEPTH=2.
  - Required: exactly 2 issues, then r0_ready=0, and r1 is still granted if valid.
  - Raising o0_ready for one cycle: r0_ready=1 in that same cycle.
- Simultaneous push/pop on a one-entry FIFO with o0_ready=1: count stays 1, and o0_data advances to the new result.
- Reset mid-flight: issue 2 ops, assert rst at cycle 1 for one cycle.
  - Required: o0_valid stays 0 forever after, even though fpu_result toggles at cycles 3–4.
  - busy=0 from cycle 2; the next tie is granted to requester 0.
- Idle cycle: no valids. Required: fpu_a=fpu_b=0, fpu_op=0, and no FIFO writes at cycle +LATENCY.
